// File: rtl/snn_pkg.sv
// Shared widths and the pending-spike slot record for the SNN datapath.
package snn_pkg;

  localparam int unsigned DLY_W = 16;
  localparam int unsigned ID_W  = 8;
  localparam int unsigned TS_W  = 16;

  typedef struct packed {
    logic             valid;
    logic             presented;
    logic [DLY_W-1:0] cnt;
    logic [TS_W-1:0]  due;
    logic [ID_W-1:0]  id;
  } slot_t;

endpackage

// File: rtl/lowest_set_idx.sv
// Priority picker: reports whether any bit is set and the index of the lowest one.
module lowest_set_idx #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         vec,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/axon_spike_scheduler.sv
// Buffers soma spikes as delayed events and emits each one to the router when its
// delay has counted down, over a valid/ready handshake.
module axon_spike_scheduler
  import snn_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ID_W-1:0]          neuron_id,
  input  logic [DLY_W-1:0]         spike_in,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [ID_W-1:0]          ev_id,
  output logic [TS_W-1:0]          ev_ts,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [TS_W-1:0]  now_q, now_d;
  slot_t            slots_q [DEPTH];
  slot_t            slots_d [DEPTH];
  logic             ev_valid_q, ev_valid_d;
  logic [ID_W-1:0]  ev_id_q, ev_id_d;
  logic [TS_W-1:0]  ev_ts_q, ev_ts_d;
  logic [IDX_W-1:0] pres_idx_q, pres_idx_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;

  logic [DEPTH-1:0] free_vec, exp_vec;
  logic             free_found, exp_found;
  logic [IDX_W-1:0] free_idx, exp_idx;
  logic             capture, capture_ok, handshake, load;

  always_comb begin
    free_vec = '0;
    exp_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = ~slots_q[i].valid;
      exp_vec[i]  = slots_q[i].valid & ~slots_q[i].presented & (slots_q[i].cnt == '0);
    end
  end

  lowest_set_idx #(
    .N (DEPTH)
  ) u_free_pick (
    .vec   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  lowest_set_idx #(
    .N (DEPTH)
  ) u_exp_pick (
    .vec   (exp_vec),
    .found (exp_found),
    .idx   (exp_idx)
  );

  assign capture    = en && (spike_in != '0);
  assign capture_ok = capture && free_found;
  assign handshake  = ev_valid_q && ev_ready;
  // Output register refills on the same edge it drains, giving one event per cycle.
  assign load       = (!ev_valid_q || handshake) && exp_found;

  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (en && slots_q[i].valid && (slots_q[i].cnt != '0)) begin
        slots_d[i].cnt = slots_q[i].cnt - DLY_W'(1);
      end
    end
    if (handshake) begin
      slots_d[pres_idx_q] = '0;
    end
    if (load) begin
      slots_d[exp_idx].presented = 1'b1;
    end
    // Target slot was free before this edge, so it is never also decremented or released.
    if (capture_ok) begin
      slots_d[free_idx].valid     = 1'b1;
      slots_d[free_idx].presented = 1'b0;
      slots_d[free_idx].cnt       = spike_in;
      slots_d[free_idx].due       = now_q + TS_W'(spike_in);
      slots_d[free_idx].id        = neuron_id;
    end
  end

  always_comb begin
    now_d      = en ? now_q + TS_W'(1) : now_q;
    ev_valid_d = ev_valid_q;
    ev_id_d    = ev_id_q;
    ev_ts_d    = ev_ts_q;
    pres_idx_d = pres_idx_q;
    pending_d  = pending_q;
    overflow_d = overflow_q || (capture && !free_found);

    if (handshake) begin
      ev_valid_d = 1'b0;
    end
    if (load) begin
      ev_valid_d = 1'b1;
      ev_id_d    = slots_q[exp_idx].id;
      ev_ts_d    = slots_q[exp_idx].due;
      pres_idx_d = exp_idx;
    end

    if (capture_ok && !handshake) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (!capture_ok && handshake) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now_q      <= '0;
      slots_q    <= '{default: '0};
      ev_valid_q <= 1'b0;
      ev_id_q    <= '0;
      ev_ts_q    <= '0;
      pres_idx_q <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      now_q      <= now_d;
      slots_q    <= slots_d;
      ev_valid_q <= ev_valid_d;
      ev_id_q    <= ev_id_d;
      ev_ts_q    <= ev_ts_d;
      pres_idx_q <= pres_idx_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_id    = ev_id_q;
  assign ev_ts    = ev_ts_q;
  assign pending  = pending_q;
  assign full     = (pending_q == CNT_W'(DEPTH));
  assign overflow = overflow_q;

endmodule
